// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pkg
// Purpose  : Shared definitions for the multi-cycle ALU: op-code constants,
//            FSM state encoding and the helper that tells which ops go
//            through the iterative datapath.
// Config   : ALU_MC_DIV_EN -- when defined, DIVU is an iterative op;
//            otherwise op 10 is treated as illegal.
// Revision : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ITER = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // True for ops that need the WIDTH-step iteration datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_iter
// Purpose  : Shared shift-add multiply / restoring-divide iteration engine.
//            start_i loads the operands; WIDTH iterations follow (counter
//            WIDTH-1 down to 0). done_o is high during the last iteration,
//            and lo_o/hi_o then carry that iteration's final values so the
//            caller can capture them on the same edge.
// Ports    : clk, rst_n (async, active low), start_i, is_div_i, a_i, b_i,
//            done_o, lo_o (product low / quotient), hi_o (product high /
//            remainder).
// Config   : ALU_MC_DIV_EN -- enables the restoring-divide step.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opb_q;   // multiplicand / divisor
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   w_sum;

`ifdef ALU_MC_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   w_trial;
`else
  logic             w_unused_div;
  assign w_unused_div = is_div_i;
`endif

  always_comb begin
    // Multiply step: add multiplicand when the multiplier LSB is set, then
    // shift {carry, acc, lo} right by one.
    w_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    acc_d = w_sum[WIDTH:1];
    lo_d  = {w_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract; a borrow (MSB set) means restore and record a 0.
    w_trial = {acc_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
    if (div_q) begin
      acc_d = w_trial[WIDTH] ? {acc_q[WIDTH-2:0], lo_q[WIDTH-1]} : w_trial[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], ~w_trial[WIDTH]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
`ifdef ALU_MC_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH - 1);
      acc_q  <= '0;
      lo_q   <= a_i;
      opb_q  <= b_i;
`ifdef ALU_MC_DIV_EN
      div_q  <= is_div_i;
`endif
    end else if (busy_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  assign done_o = busy_q && (cnt_q == '0);
  assign lo_o   = lo_d;
  assign hi_o   = acc_d;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU behind valid/ready handshakes. Single-cycle ops
//            (add/sub/logic/shift/rotate) complete in one cycle; MUL and
//            DIVU run WIDTH iterations in alu_mc_iter (latency WIDTH+1).
// Ports    : clk, rst_n (async, active low)
//            in_valid_i/in_ready_o, op_i, a_i, b_i, cin_i   -- request
//            out_valid_o/out_ready_i, result_o, result_hi_o,
//            cout_o, ofl_o, zero_o, neg_o, dz_o            -- response
// Config   : ALU_MC_DIV_EN -- when undefined the divider is removed and
//            op 10 behaves as an illegal op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             cout_o,
  output logic             ofl_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             dz_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cout_q, cout_d;
  logic             ofl_q, ofl_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;

  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_opb;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH-1:0]   w_res, w_hi;
  logic               w_cout, w_ofl, w_dz;
  logic               w_div0, w_iter_go, w_start;
  logic               w_iter_done;
  logic [WIDTH-1:0]   w_iter_lo, w_iter_hi;

  assign w_sh  = b_i[SHW-1:0];
  // SUB reuses the adder with inverted B and a forced carry-in.
  assign w_opb = (op_i == OP_SUB) ? ~b_i : b_i;
  assign w_sum = {1'b0, a_i} + {1'b0, w_opb}
               + {{WIDTH{1'b0}}, ((op_i == OP_SUB) ? 1'b1 : cin_i)};
  // Rotate-left: upper half of the doubled operand shifted left.
  assign w_rot = {a_i, a_i} << w_sh;

  // Divide by zero is resolved immediately instead of iterating.
  assign w_div0    = (op_i == OP_DIVU) && (b_i == '0);
  assign w_iter_go = is_iter_op(op_i) && !w_div0;
  assign w_start   = (state_q == ST_IDLE) && in_valid_i && w_iter_go;

  always_comb begin
    w_res  = '0;
    w_hi   = '0;
    w_cout = 1'b0;
    w_ofl  = 1'b0;
    w_dz   = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ofl  = (a_i[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: w_res = a_i & b_i;
      OP_OR:  w_res = a_i | b_i;
      OP_XOR: w_res = a_i ^ b_i;
      OP_SLL: w_res = a_i << w_sh;
      OP_SRL: w_res = a_i >> w_sh;
      OP_SRA: w_res = $unsigned($signed(a_i) >>> w_sh);
      OP_ROL: w_res = w_rot[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
      // Only reached as a single-cycle op when the divisor is zero.
      OP_DIVU: begin
        w_res = '1;
        w_hi  = a_i;
        w_dz  = 1'b1;
      end
`endif
      default: ;  // illegal ops: all-zero result and flags
    endcase
  end

  alu_mc_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (w_start),
    .is_div_i (op_i == OP_DIVU),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (w_iter_done),
    .lo_o     (w_iter_lo),
    .hi_o     (w_iter_hi)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    cout_d   = cout_q;
    ofl_d    = ofl_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          if (w_iter_go) begin
            state_d = ST_ITER;
          end else begin
            state_d  = ST_DONE;
            result_d = w_res;
            hi_d     = w_hi;
            cout_d   = w_cout;
            ofl_d    = w_ofl;
            zero_d   = (w_res == '0);
            neg_d    = w_res[WIDTH-1];
            dz_d     = w_dz;
          end
        end
      end
      ST_ITER: begin
        if (w_iter_done) begin
          state_d  = ST_DONE;
          result_d = w_iter_lo;
          hi_d     = w_iter_hi;
          cout_d   = 1'b0;
          ofl_d    = 1'b0;
          zero_d   = (w_iter_lo == '0);
          neg_d    = w_iter_lo[WIDTH-1];
          dz_d     = 1'b0;
        end
      end
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      cout_q   <= 1'b0;
      ofl_q    <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      cout_q   <= cout_d;
      ofl_q    <= ofl_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready_o  = (state_q == ST_IDLE) && rst_n;
  assign out_valid_o = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign result_hi_o = hi_q;
  assign cout_o      = cout_q;
  assign ofl_o       = ofl_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
  assign dz_o        = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc: directed test-plan cases plus
//            randomized ops, compared every cycle against a behavioural model
//            of the ALU and its handshake timing.
// Config   : honours ALU_MC_DIV_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W    = 16;
  localparam int SH   = 4;
  localparam int MAXS = (1 << (W-1)) - 1;
  localparam int MINS = -(1 << (W-1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result, result_hi;
  logic         cout, ofl, zero, neg, dz;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] cap_res, cap_hi;
  logic         cap_cout, cap_ofl, cap_zero, cap_neg, cap_dz;
  int           cap_lat;

  always #5 clk = ~clk;

  alu_mc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .cin_i(cin),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .result_hi_o(result_hi),
    .cout_o(cout), .ofl_o(ofl), .zero_o(zero), .neg_o(neg), .dz_o(dz)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout, ofl, zero, neg, dz;
    int           lat;
    int           due;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: arithmetic straight from the op definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t   e;
    int     s, t, sx, sy, sh;
    longint p;
    logic [W-1:0] r;
    e.res = '0; e.hi = '0; e.cout = 1'b0; e.ofl = 1'b0; e.dz = 1'b0; e.lat = 1; e.due = 0;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[SH-1:0]);
    case (o)
      OP_ADD: begin
        s = int'(x) + int'(y) + int'(c);
        e.res = s[W-1:0]; e.cout = s[W];
        t = sx + sy + int'(c);
        e.ofl = (t > MAXS) || (t < MINS);
      end
      OP_SUB: begin
        s = int'(x) - int'(y);
        e.res = s[W-1:0]; e.cout = (x >= y);
        t = sx - sy;
        e.ofl = (t > MAXS) || (t < MINS);
      end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_SLL: e.res = x << sh;
      OP_SRL: e.res = x >> sh;
      OP_SRA: begin r = x; repeat (sh) r = {r[W-1], r[W-1:1]}; e.res = r; end
      OP_ROL: begin r = x; repeat (sh) r = {r[W-2:0], r[W-1]}; e.res = r; end
      OP_MUL: begin
        p = longint'(x) * longint'(y);
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 1;
      end
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        if (y == '0) begin e.res = '1; e.hi = x; e.dz = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; e.lat = W + 1; end
      end
`endif
      default: ;
    endcase
    e.zero = (e.res == '0);
    e.neg  = e.res[W-1];
    return e;
  endfunction

  // Compare process: tracks accepts/completions from the handshake rules and
  // checks every DUT output on every cycle.
  initial begin
    int   cyc;
    bit   prev_empty, prev_vld, exp_vld;
    exp_t e;
    cyc = 0; prev_empty = 1'b1; prev_vld = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        q.delete(); prev_empty = 1'b1; prev_vld = 1'b0;
        chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 0);
        chk("rst_result", result, 0);       chk("rst_result_hi", result_hi, 0);
        chk("rst_zero", zero, 1);           chk("rst_flags", {cout, ofl, neg, dz}, 0);
        continue;
      end
      if (prev_vld && out_ready) void'(q.pop_front());
      if (prev_empty && in_valid) begin
        e = model(op, a, b, cin);
        e.due = cyc + e.lat - 1;
        q.push_back(e);
      end
      exp_vld = (q.size() > 0) && (cyc >= q[0].due);
      chk("out_valid", out_valid, exp_vld);
      chk("in_ready", in_ready, q.size() == 0);
      if (exp_vld && out_valid) begin
        chk("result", result, q[0].res);
        chk("result_hi", result_hi, q[0].hi);
        chk("cout", cout, q[0].cout);
        chk("ofl", ofl, q[0].ofl);
        chk("zero", zero, q[0].zero);
        chk("neg", neg, q[0].neg);
        chk("dz", dz, q[0].dz);
      end
      prev_empty = (q.size() == 0);
      prev_vld   = exp_vld;
    end
  end

  // Issue one op (call at a negedge), wait for the response, hold it for
  // 'hold' cycles, then accept it. Optionally pulse in_valid while busy.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input int hold, input bit noise);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk("issue_wait", in_ready, 1);
    op = o; a = x; b = y; cin = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    chk("result_wait", out_valid, 1);
    cap_res = result; cap_hi = result_hi; cap_cout = cout; cap_ofl = ofl;
    cap_zero = zero; cap_neg = neg; cap_dz = dz; cap_lat = k + 1;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    // Pin the model with hand-computed values.
    m = model(OP_MUL, 16'h1234, 16'h5678, 1'b0);
    chk("model_mul_lo", m.res, 16'h0060); chk("model_mul_hi", m.hi, 16'h0626);
    m = model(OP_SUB, 16'h0000, 16'h8000, 1'b0);
    chk("model_sub_ofl", m.ofl, 1);
    m = model(OP_SRA, 16'h8010, 16'h0004, 1'b0);
    chk("model_sra", m.res, 16'hF801);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
    chk("add_res", cap_res, 16'h8000); chk("add_ofl", cap_ofl, 1); chk("add_neg", cap_neg, 1);
    chk("add_cout", cap_cout, 0);      chk("add_zero", cap_zero, 0); chk("add_lat", cap_lat, 1);

    issue(OP_SUB, 16'h0005, 16'h0005, 1'b0, 3, 0);
    chk("sub_res", cap_res, 0); chk("sub_zero", cap_zero, 1);
    chk("sub_cout", cap_cout, 1); chk("sub_ofl", cap_ofl, 0);

    issue(OP_SRA, 16'h8010, 16'h0004, 1'b0, 0, 0); chk("sra_res", cap_res, 16'hF801);
    issue(OP_ROL, 16'h8001, 16'h0004, 1'b0, 0, 0); chk("rol_res", cap_res, 16'h0018);
    issue(OP_SLL, 16'h1234, 16'h0010, 1'b0, 0, 0); chk("sll0_res", cap_res, 16'h1234);

    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 1, 1);
    chk("mul_lo", cap_res, 16'h0001); chk("mul_hi", cap_hi, 16'hFFFE); chk("mul_lat", cap_lat, 17);

    issue(OP_DIVU, 16'd100, 16'd7, 1'b0, 0, 0);
`ifdef ALU_MC_DIV_EN
    chk("div_q", cap_res, 16'd14); chk("div_r", cap_hi, 16'd2); chk("div_lat", cap_lat, 17);
`else
    chk("div_ill_res", cap_res, 0); chk("div_ill_zero", cap_zero, 1); chk("div_ill_lat", cap_lat, 1);
`endif
    issue(OP_DIVU, 16'd100, 16'd0, 1'b0, 0, 0);
`ifdef ALU_MC_DIV_EN
    chk("dz_res", cap_res, 16'hFFFF); chk("dz_hi", cap_hi, 16'd100);
    chk("dz_flag", cap_dz, 1); chk("dz_lat", cap_lat, 1);
`else
    chk("dz_ill_res", cap_res, 0); chk("dz_ill_zero", cap_zero, 1); chk("dz_ill_flag", cap_dz, 0);
`endif
    issue(4'd13, 16'hABCD, 16'h1234, 1'b1, 0, 0);
    chk("ill_res", cap_res, 0); chk("ill_zero", cap_zero, 1);

    // Reset in the middle of a MUL iteration.
    op = OP_MUL; a = 16'h00FF; b = 16'h0F0F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0); chk("abort_zero", zero, 1);
    chk("abort_res", result, 0);      chk("abort_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", in_ready, 1);
    @(negedge clk);
    issue(OP_ADD, 16'd2, 16'd3, 1'b0, 0, 0);
    chk("post_rst_add", cap_res, 16'd5);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ro = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIVU;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = '1;
        2: rb = W'($urandom_range(0, 15));
        3: ra = 16'h8000;
        default: ;
      endcase
      issue(ro, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle 16-bit ALU.
- Single-cycle ops (add/sub/logic/shift/rotate) return in one registered cycle.
- Iterative ops (shift-add multiply, restoring unsigned divide) take WIDTH+1 cycles.
- Sits between decode and writeback behind a valid/ready handshake, so the pipeline can stall on long ops.

Parameters:
- WIDTH, 16, operand/result width; must be ≥4 and a power of 2.
- SHW, $clog2(WIDTH), shift-count bits taken from B[SHW-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an op.
- op  input  4  operation code (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for ADD; ignored by every other op.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  main result; for MUL the low half, for DIVU the quotient.
- result_hi  output  WIDTH  MUL high half or DIVU remainder; 0 for all other ops.
- cout  output  1  carry out (ADD/SUB only, else 0).
- ofl  output  1  signed overflow (ADD/SUB only, else 0).
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- dz  output  1  divide by zero (DIVU only).

Behaviour:
- Op codes:
  - 0 ADD: a+b+cin.
  - 1 SUB: a+~b+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, 8 ROL; count = b[SHW-1:0].
  - 9 MUL: unsigned, full 2*WIDTH-bit product.
  - 10 DIVU.
  - 11-15 illegal.
- FSM states:
  - IDLE: in_ready=1.
  - ITER: counter runs WIDTH-1 down to 0; in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE & in_valid & single-cycle op -> DONE next edge; latency 1.
  - IDLE & in_valid & MUL/DIVU -> ITER (operands latched); after WIDTH iterations -> DONE; latency WIDTH+1.
  - DONE & out_ready -> IDLE.
  - No overlap: no new op is accepted in the cycle DONE is left.
- Output hold: all outputs are registered and stay stable while out_valid=1 and out_ready=0.
- Overflow: ofl = (opA[W-1]==opB'[W-1]) & (result[W-1]!=opA[W-1]), where opB' is the post-inversion B. It is computed on operands versus the sum, never on B versus Out.
- cout: carry out of bit WIDTH-1.
- Shifts: count 0 returns a unchanged; SRA fills with a[W-1]; ROL wraps.
- Divide by zero (b==0):
  - Completes in 1 cycle, not WIDTH+1.
  - result = all ones, result_hi = a, dz = 1.
- Illegal op: completes in 1 cycle with result = 0, zero = 1, all other flags 0.
- in_valid while busy is ignored; the upstream stage must hold its request.
- Reset: asynchronous assert at any time, including mid-ITER, aborts the op.
  - State -> IDLE.
  - result, result_hi, cout, ofl, neg, dz, out_valid -> 0.
  - zero -> 1.
  - in_ready = 1 only after rst_n deasserts.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: DIVU is implemented as above.
- Undefined:
  - Divider datapath is removed.
  - Op 10 is treated as illegal (1-cycle, result 0, zero=1, dz=0).
  - MUL is unaffected.

Decomposition:
- Shared package alu_mc_pkg holds:
  - Op-code constants (OP_ADD..OP_DIVU).
  - FSM state typedef (IDLE/ITER/DONE).
  - Function is_iter_op(op).
- One natural sub-module: alu_mc_iter, the shared shift-add/restoring-subtract iteration datapath with its counter.
  - Instantiated once.
  - Start/done pulse interface to the top-level FSM.

Test Plan:
- ADD a=16'h7FFF b=16'h0001 cin=0 -> 1 cycle later out_valid=1, result=16'h8000, ofl=1, neg=1, cout=0, zero=0.
- SUB a=16'h0005 b=16'h0005 -> result=0, zero=1, cout=1, ofl=0; hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- SRA a=16'h8010 b=16'h0004 -> result=16'hF801; ROL a=16'h8001 b=4 -> result=16'h0018; SLL count 0 -> result unchanged.
- MUL a=16'hFFFF b=16'hFFFF -> out_valid exactly 17 cycles after accept, result=16'h0001, result_hi=16'hFFFE; in_valid pulses during ITER ignored.
- DIVU a=100 b=7 -> quotient 14, remainder 2 after 17 cycles; b=0 -> 1 cycle, result=16'hFFFF, result_hi=100, dz=1; without ALU_MC_DIV_EN -> result=0, zero=1.
- Assert rst_n=0 at iteration 8 of a MUL -> outputs zeroed immediately (zero=1); after release, in_ready=1 and a new ADD 2+3 returns 5.
